jtag_seq: RTL and testbench

JTAG_SEQ -- requirements
Module: jtag_seq

---
 rtl/jtag_seq_pkg.sv | 44 ++++
 rtl/jtag_seq_shreg.sv | 45 ++++
 rtl/jtag_seq.sv | 186 ++++++++++++++++++
 tb/tb_jtag_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_seq_pkg.sv
// Shared encodings and TAP walk lengths for the JTAG command sequencer.
package jtag_seq_pkg;

    localparam int MAX_LEN_DEF = 32;
    localparam int PRE_DR_LEN  = 3;   // Idle -> Select-DR -> Capture-DR -> Shift-DR
    localparam int PRE_IR_LEN  = 4;   // Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
    localparam int RST_RUN_LEN = 5;   // TMS=1 cycles that reach Test-Logic-Reset from anywhere

    typedef enum logic [1:0] {
        OP_RESET    = 2'd0,
        OP_SHIFT_IR = 2'd1,
        OP_SHIFT_DR = 2'd2,
        OP_RUN_IDLE = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_READY = 3'd1,
        ST_PRE   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_POST  = 3'd4,
        ST_RUN   = 3'd5,
        ST_RESP  = 3'd6
    } state_e;

    // Index of the final step of the TMS walk issued before SHIFT (or before RESP for RESET).
    function automatic logic [2:0] pre_last(op_e op);
        case (op)
            OP_SHIFT_DR: pre_last = 3'(PRE_DR_LEN - 1);
            OP_SHIFT_IR: pre_last = 3'(PRE_IR_LEN - 1);
            default:     pre_last = 3'(RST_RUN_LEN);     // five ones, then a zero into Idle
        endcase
    endfunction

    // TMS for a given step of that walk: leading ones, trailing zeros.
    function automatic logic pre_tms(op_e op, logic [2:0] step);
        case (op)
            OP_SHIFT_DR: pre_tms = (step < 3'(PRE_DR_LEN - 2));
            OP_SHIFT_IR: pre_tms = (step < 3'(PRE_IR_LEN - 2));
            default:     pre_tms = (step < 3'(RST_RUN_LEN));
        endcase
    endfunction

endpackage

// File: rtl/jtag_seq_shreg.sv
// TDI shift-out / TDO capture register. Bit 0 is the TDI bit of the current
// shift cycle; each shift moves the register down and drops TDO into bit len-1,
// so after len shifts the captured bits sit right-aligned with zeros above.
module jtag_seq_shreg import jtag_seq_pkg::*; #(
    parameter int W = MAX_LEN_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clr,
    input  logic         shift,
    input  logic [W-1:0] din,
    input  logic [5:0]   len,
    input  logic         tdo,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d, shr;

    // Next register value: clear, load payload, or shift with TDO insertion.
    always_comb begin
        shr = q_q >> 1;
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = din;
        end else if (shift) begin
            for (int j = 0; j < W; j++) begin
                if (j == int'(len) - 1)     q_d[j] = tdo;
                else if (j < int'(len) - 1) q_d[j] = shr[j];
                else                        q_d[j] = 1'b0;
            end
        end
    end

    // Register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/jtag_seq.sv
// JTAG command sequencer: turns RESET / SHIFT_IR / SHIFT_DR / RUN_IDLE commands
// into registered TMS/TDI streams, assuming the target TAP rests in Run-Test/Idle
// whenever this block is READY.
module jtag_seq import jtag_seq_pkg::*; #(
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic               tck,
    input  logic               trst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i,
    output logic               busy
);

    state_e       state_q, state_d;
    op_e          op_q, op_d;
    logic [2:0]   step_q, step_d;   // position inside INIT / PRE / POST walks
    logic [5:0]   cnt_q, cnt_d;     // remaining shift bits or idle cycles
    logic [5:0]   len_q, len_d;
    logic         err_q, err_d;
    logic         tms_q, tms_d;
    logic         tdi_q, tdi_d;
    logic         len_bad;
    logic         sh_load, sh_clr, sh_shift;
    logic [MAX_LEN-1:0] sh_q;

    assign len_bad = (cmd_len == 6'd0) || ({26'd0, cmd_len} > MAX_LEN);

    // Command sequencing: next state, counters and shift-register controls.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        err_d    = err_q;
        sh_load  = 1'b0;
        sh_clr   = 1'b0;
        sh_shift = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (step_q == 3'(RST_RUN_LEN)) begin
                    state_d = ST_READY;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_READY: begin
                if (cmd_valid) begin
                    op_d   = op_e'(cmd_op);
                    len_d  = cmd_len;
                    cnt_d  = cmd_len;
                    step_d = '0;
                    err_d  = 1'b0;
                    case (op_e'(cmd_op))
                        OP_RESET: begin
                            state_d = ST_PRE;
                            sh_clr  = 1'b1;
                        end
                        OP_RUN_IDLE: begin
                            state_d = (cmd_len == 6'd0) ? ST_RESP : ST_RUN;
                            sh_clr  = 1'b1;
                        end
                        default: begin
                            if (len_bad) begin
                                // Rejected without touching the TAP.
                                state_d = ST_RESP;
                                err_d   = 1'b1;
                                cnt_d   = '0;
                                sh_clr  = 1'b1;
                            end else begin
                                state_d = ST_PRE;
                                sh_load = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_PRE: begin
                if (step_q == pre_last(op_q)) begin
                    step_d  = '0;
                    state_d = (op_q == OP_RESET) ? ST_RESP : ST_SHIFT;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_SHIFT: begin
                sh_shift = 1'b1;
                if (cnt_q <= 6'd1) begin
                    state_d = ST_POST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_POST: begin
                if (step_q == 3'd1) begin
                    state_d = ST_RESP;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_RUN: begin
                if (cnt_q <= 6'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_READY;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // TMS/TDI for the coming cycle, derived from where the FSM is heading so the
    // pins are registered yet line up with the state they belong to.
    always_comb begin
        case (state_d)
            ST_INIT:  tms_d = (step_d < 3'(RST_RUN_LEN));
            ST_PRE:   tms_d = pre_tms(op_d, step_d);
            ST_SHIFT: tms_d = (cnt_d == 6'd1);          // last bit moves to Exit1
            ST_POST:  tms_d = (step_d == 3'd0);         // Update, then Idle
            default:  tms_d = 1'b0;                     // Idle, incl. response back-pressure
        endcase
        tdi_d = 1'b0;
        if (state_d == ST_SHIFT) tdi_d = (state_q == ST_SHIFT) ? sh_q[1] : sh_q[0];
    end

    // State and pin registers.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_q <= ST_INIT;
            op_q    <= OP_RESET;
            step_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            err_q   <= err_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
        end
    end

    jtag_seq_shreg #(.W(MAX_LEN)) u_shreg (
        .clk   (tck),
        .rst_n (trst_n),
        .load  (sh_load),
        .clr   (sh_clr),
        .shift (sh_shift),
        .din   (cmd_data),
        .len   (len_q),
        .tdo   (tdo_i),
        .q     (sh_q)
    );

    assign cmd_ready = (state_q == ST_READY);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_data  = rsp_valid ? sh_q : '0;
    assign busy      = (state_q != ST_READY) && (state_q != ST_RESP);
    assign tms_o     = tms_q;
    assign tdi_o     = tdi_q;

endmodule

// File: tb/tb_jtag_seq.sv
// Bench for jtag_seq: a TAP-state tracker plus a TDO source (random, loopback or
// IDCODE target) watch the pins; each command's TMS/TDI stream, length and
// response are compared with a model built from the command rules.
module tb_jtag_seq;

    localparam int ML = 32;
    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PSDR = 6, EX2DR = 7,
                   UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PSIR = 13, EX2IR = 14, UPIR = 15;

    logic          tck = 1'b0, trst_n = 1'b0;
    logic          cmd_valid = 1'b0, rsp_ready = 1'b1, tdo_i = 1'b0;
    logic [1:0]    cmd_op = 2'd0;
    logic [5:0]    cmd_len = 6'd0;
    logic [ML-1:0] cmd_data = '0;
    logic          cmd_ready, rsp_valid, rsp_err, tms_o, tdi_o, busy;
    logic [ML-1:0] rsp_data;

    int n_cmp = 0, n_bad = 0;
    int tdo_mode = 0;            // 0 random, 1 loopback of tdi_o, 2 IDCODE target

    typedef struct { logic tms; logic tdi; logic tdo; logic rv; logic bsy; int tap; } rec_t;
    rec_t mon[$];

    always #5 tck = ~tck;

    jtag_seq #(.MAX_LEN(ML)) dut (
        .tck(tck), .trst_n(trst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err), .tms_o(tms_o),
        .tdi_o(tdi_o), .tdo_i(tdo_i), .busy(busy)
    );

    function automatic int tap_next(int s, logic t);
        case (s)
            TLR:   return t ? TLR   : RTI;
            RTI:   return t ? SELDR : RTI;
            SELDR: return t ? SELIR : CAPDR;
            CAPDR: return t ? EX1DR : SHDR;
            SHDR:  return t ? EX1DR : SHDR;
            EX1DR: return t ? UPDR  : PSDR;
            PSDR:  return t ? EX2DR : PSDR;
            EX2DR: return t ? UPDR  : SHDR;
            SELIR: return t ? TLR   : CAPIR;
            CAPIR: return t ? EX1IR : SHIR;
            SHIR:  return t ? EX1IR : SHIR;
            EX1IR: return t ? UPIR  : PSIR;
            PSIR:  return t ? EX2IR : PSIR;
            EX2IR: return t ? UPIR  : SHIR;
            default: return t ? SELDR : RTI;   // Update-DR / Update-IR
        endcase
    endfunction

    // Target side: mid-cycle, choose TDO for this cycle, log the pins, advance the TAP.
    int            tap = TLR;
    logic [31:0]   dr  = '0;
    always @(negedge tck) begin
        if (!trst_n) begin
            tap = TLR;
        end else begin
            case (tdo_mode)
                1:       tdo_i = tdi_o;
                2:       tdo_i = (tap == SHDR) ? dr[0] : 1'b0;
                default: tdo_i = 1'($urandom_range(0, 1));
            endcase
            mon.push_back('{tms: tms_o, tdi: tdi_o, tdo: tdo_i, rv: rsp_valid, bsy: busy, tap: tap});
            if (tap == CAPDR)     dr = 32'h0000_0001;
            else if (tap == SHDR) dr = {tdi_o, dr[31:1]};
            tap = tap_next(tap, tms_o);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " pins"}, 128'({tms_o, tdi_o, cmd_ready, rsp_valid, rsp_err, busy}), 128'(6'b100001));
        chk({tag, " data"}, 128'(rsp_data), 128'(0));
    endtask

    // Release reset just after a rising edge and watch the INIT walk.
    task automatic init_seq(input string tag);
        logic [5:0] tms_seen, hs_seen;
        @(posedge tck); #1; trst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge tck); #1;
            tms_seen[i] = tms_o;
            hs_seen[i]  = cmd_ready | rsp_valid;
        end
        chk({tag, " init tms"}, 128'(tms_seen), 128'(6'b011111));
        chk({tag, " init handshakes low"}, 128'(hs_seen), 128'(0));
        @(negedge tck); #1;
        chk({tag, " cycle7 ready/busy"}, 128'({cmd_ready, busy}), 128'(2'b10));
    endtask

    // Issue one command (at negedge+1) and check it against the command rules.
    task automatic run_cmd(input logic [1:0] op, input int len, input logic [ML-1:0] data,
                           input int hold, input string tag, output logic [ML-1:0] got_data);
        int start, n, k, elen, nsh, ix, endtap;
        bit shiftop, bad, allbusy;
        logic [127:0] etms, etdi, gtms, gtdi;
        logic [ML-1:0] edata;
        shiftop = (op == 2'd1) || (op == 2'd2);
        bad     = shiftop && (len == 0 || len > ML);
        chk({tag, " ready"}, 128'(cmd_ready), 128'(1));
        rsp_ready = (hold == 0);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = 6'(len); cmd_data = data;
        @(posedge tck); #1;
        cmd_valid = 1'b0;
        start = mon.size();
        k = 0;
        do begin
            @(negedge tck); #1; k++;
        end while (!rsp_valid && k < 300);
        chk({tag, " rsp arrives"}, 128'(rsp_valid), 128'(1));

        // Expected pin streams, straight from the command rules.
        etms = '0; etdi = '0; elen = 0;
        if (op == 2'd0) begin
            for (int i = 0; i < 5; i++) begin etms[elen] = 1'b1; elen++; end
            elen++;
        end else if (op == 2'd3) begin
            elen = len;
        end else if (!bad) begin
            for (int i = 0; i < ((op == 2'd1) ? 2 : 1); i++) begin etms[elen] = 1'b1; elen++; end
            elen += 2;
            for (int i = 0; i < len; i++) begin
                etms[elen] = (i == len - 1);
                etdi[elen] = data[i];
                elen++;
            end
            etms[elen] = 1'b1; elen += 2;
        end

        // Observed streams up to the first response cycle; TDO kept where the TAP was shifting.
        n = 0; gtms = '0; gtdi = '0; edata = '0; nsh = 0; allbusy = 1'b1;
        while (start + n < mon.size() && !mon[start + n].rv) n++;
        for (int i = 0; i < n && i < 128; i++) begin
            ix = start + i;
            gtms[i] = mon[ix].tms;
            gtdi[i] = mon[ix].tdi;
            allbusy &= mon[ix].bsy;
            if (mon[ix].tap == SHDR || mon[ix].tap == SHIR) begin
                if (nsh < ML) edata[nsh] = mon[ix].tdo;
                nsh++;
            end
        end
        endtap = (start + n < mon.size()) ? mon[start + n].tap : -1;

        chk({tag, " tap cycles"}, 128'(n), 128'(elen));
        chk({tag, " tms stream"}, gtms, etms);
        chk({tag, " tdi stream"}, gtdi, etdi);
        chk({tag, " shift bits"}, 128'(nsh), 128'((shiftop && !bad) ? len : 0));
        chk({tag, " rsp_data"}, 128'(rsp_data), 128'(edata));
        chk({tag, " rsp_err"}, 128'(rsp_err), 128'(bad));
        chk({tag, " resp tms/busy"}, 128'({tms_o, busy}), 128'(0));
        chk({tag, " busy while active"}, 128'(allbusy), 128'(1));
        chk({tag, " tap ends idle"}, 128'(endtap), 128'(RTI));
        got_data = rsp_data;

        for (int i = 0; i < hold; i++) begin
            @(negedge tck); #1;
            chk({tag, " backpressure"}, 128'({tms_o, rsp_valid, cmd_ready}), 128'(3'b010));
        end
        rsp_ready = 1'b1;
        @(negedge tck); #1;
    endtask

    initial begin
        logic [ML-1:0] got;
        int            k, nshift;
        logic [1:0]    op;
        int            len, hold;

        repeat (3) @(negedge tck);
        #1;
        chk_reset("reset");
        init_seq("boot");

        tdo_mode = 2;
        run_cmd(2'd2, 32, $urandom, 0, "idcode dr32", got);
        chk("idcode value", 128'(got), 128'(32'h0000_0001));

        tdo_mode = 1;
        run_cmd(2'd1, 4, 32'hA, 0, "ir4 loopback", got);
        chk("ir4 loopback value", 128'(got), 128'(4'hA));

        tdo_mode = 0;
        run_cmd(2'd2, 0,  $urandom, 0, "dr len0", got);
        run_cmd(2'd2, 40, $urandom, 0, "dr len40", got);
        run_cmd(2'd1, 33, $urandom, 0, "ir len33", got);
        run_cmd(2'd3, 3,  '0, 10, "run3 held", got);
        run_cmd(2'd3, 0,  '0, 0, "run0", got);
        run_cmd(2'd0, 0,  '0, 0, "reset op", got);
        run_cmd(2'd2, 1,  $urandom, 0, "dr len1", got);
        run_cmd(2'd1, 32, $urandom, 0, "ir len32", got);

        for (int t = 0; t < 40; t++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = $urandom_range(ML + 1, 63);
                default: len = $urandom_range(1, ML);
            endcase
            if (op == 2'd3) len = $urandom_range(0, 12);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            tdo_mode = $urandom_range(0, 1);
            run_cmd(op, len, $urandom, hold, $sformatf("rnd%0d op%0d len%0d", t, op, len), got);
        end

        // Pull reset during bit 10 of a 32-bit DR shift.
        tdo_mode = 0;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_len = 6'd32; cmd_data = $urandom;
        @(posedge tck); #1;
        cmd_valid = 1'b0;
        k = 0; nshift = 0;
        while (nshift < 11 && k < 100) begin
            @(negedge tck); #1; k++;
            nshift += (mon[mon.size() - 1].tap == SHDR) ? 1 : 0;
        end
        chk("midrst reached bit10", 128'(nshift), 128'(11));
        trst_n = 1'b0;
        #1;
        chk_reset("midrst");
        repeat (2) @(negedge tck);
        #1;
        chk_reset("midrst held");
        init_seq("rerun");
        run_cmd(2'd2, 8, $urandom, 0, "after rerun", got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
